// File: rtl/seq_pattern_detector_pkg.sv
// pattern_pkg: shared FSM states, mode encodings and default widths for the pattern detector.
package pattern_pkg;
   localparam int DEF_PAT_W = 4;
   localparam int DEF_CNT_W = 16;
   localparam logic OVERLAP = 1'b1;
   localparam logic NON_OVERLAP = 1'b0;
   localparam logic MEALY = 1'b0;
   localparam logic MOORE = 1'b1;
   typedef enum logic {S_FILL, S_ARMED} state_e;
endpackage

// File: rtl/seq_pattern_detector_sat_counter.sv
// sat_counter: saturating up-counter with a sticky flag, set when an increment hits all-ones.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             sat_o
);
   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic sat_d, sat_q, full;
   always_comb begin
      full = &cnt_q;
      cnt_d = clr_i ? '0 : (inc_i && !full) ? cnt_q + 1'b1 : cnt_q;
      sat_d = clr_i ? 1'b0 : sat_q | (inc_i & full);
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         sat_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         sat_q <= sat_d;
      end
   end
   assign cnt_o = cnt_q;
   assign sat_o = sat_q;
endmodule

// File: rtl/seq_pattern_detector.sv
// seq_pattern_detector: configurable serial pattern detector with overlap/non-overlap,
// Mealy/Moore output timing and a saturating match counter.
module seq_pattern_detector import pattern_pkg::*; #(
   parameter int               PAT_W     = DEF_PAT_W,
   parameter int               CNT_W     = DEF_CNT_W,
   parameter logic [PAT_W-1:0] PAT_RST   = PAT_W'(4'b1011),
   parameter logic             OVL_RST   = OVERLAP,
   parameter logic             MOORE_RST = MEALY
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   input  logic             d_in,
   input  logic             cfg_load_i,
   input  logic [PAT_W-1:0] pattern_i,
   input  logic             overlap_i,
   input  logic             moore_i,
   output logic             pattern_detected,
   output logic [CNT_W-1:0] match_count_o,
   output logic             cnt_sat_o
);
   localparam int HW = PAT_W - 1;
   localparam int FW = $clog2(PAT_W);
   localparam logic [FW-1:0] FILL_MAX = FW'(PAT_W - 1);
   logic [PAT_W-1:0] pat_d, pat_q;
   logic ovl_d, ovl_q, moore_d, moore_q, det_d, det_q;
   logic [HW-1:0] hist_d, hist_q;
   logic [FW-1:0] fill_d, fill_q;
   state_e state_d, state_q;
   logic accepted, match_now;
   always_comb begin
      accepted = valid_i && !cfg_load_i;
      match_now = accepted && state_q == S_ARMED && {hist_q, d_in} == pat_q;
      pat_d = cfg_load_i ? pattern_i : pat_q;
      ovl_d = cfg_load_i ? overlap_i : ovl_q;
      moore_d = cfg_load_i ? moore_i : moore_q;
      hist_d = cfg_load_i ? '0 : accepted ? HW'({hist_q, d_in}) : hist_q;
      // a non-overlapping match restarts the fill so the next match needs PAT_W fresh bits
      fill_d = cfg_load_i ? '0 :
               (match_now && ovl_q == NON_OVERLAP) ? '0 :
               (accepted && fill_q != FILL_MAX) ? fill_q + 1'b1 : fill_q;
      state_d = fill_d == FILL_MAX ? S_ARMED : S_FILL;
      det_d = match_now;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pat_q   <= PAT_RST;
         ovl_q   <= OVL_RST;
         moore_q <= MOORE_RST;
         hist_q  <= '0;
         fill_q  <= '0;
         state_q <= S_FILL;
         det_q   <= 1'b0;
      end else begin
         pat_q   <= pat_d;
         ovl_q   <= ovl_d;
         moore_q <= moore_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         state_q <= state_d;
         det_q   <= det_d;
      end
   end
   assign pattern_detected = moore_q == MOORE ? det_q : match_now;
   sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (cfg_load_i),
      .inc_i (match_now),
      .cnt_o (match_count_o),
      .sat_o (cnt_sat_o)
   );
endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb_seq_pattern_detector: directed plus random stimulus against a queue-based model of the detector.
module tb_seq_pattern_detector;
   localparam int PAT_W = 4;
   logic clk = 1'b0;
   logic rst_i = 1'b1, valid_i = 1'b0, d_in = 1'b0, cfg_load_i = 1'b0, overlap_i = 1'b0, moore_i = 1'b0;
   logic [PAT_W-1:0] pattern_i = '0;
   logic det, det_s, sat, sat_s;
   logic [15:0] cnt;
   logic [2:0] cnt_s;
   int n_cmp = 0, n_bad = 0;
   bit q[$];
   logic [3:0] m_pat = 4'b1011;
   bit m_ovl = 1'b1, m_moore = 1'b0, prev = 1'b0;
   int m_cnt = 0;

   always #5 clk = ~clk;

   seq_pattern_detector u_dut (
      .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .d_in(d_in), .cfg_load_i(cfg_load_i),
      .pattern_i(pattern_i), .overlap_i(overlap_i), .moore_i(moore_i),
      .pattern_detected(det), .match_count_o(cnt), .cnt_sat_o(sat));

   seq_pattern_detector #(.CNT_W(3)) u_sat (
      .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .d_in(d_in), .cfg_load_i(cfg_load_i),
      .pattern_i(pattern_i), .overlap_i(overlap_i), .moore_i(moore_i),
      .pattern_detected(det_s), .match_count_o(cnt_s), .cnt_sat_o(sat_s));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit model_match(bit v, bit c, bit d);
      int w = 0;
      if (c || !v || q.size() < PAT_W - 1) return 1'b0;
      foreach (q[i]) w = (w << 1) | int'(q[i]);
      w = (w << 1) | int'(d);
      return w[3:0] == m_pat;
   endfunction

   task automatic step(input bit r, input bit c, input bit v, input bit d,
                       input logic [3:0] p, input bit o, input bit m);
      bit mt;
      rst_i = r; cfg_load_i = c; valid_i = v; d_in = d; pattern_i = p; overlap_i = o; moore_i = m;
      @(negedge clk);
      mt = model_match(v, c, d);
      if (!r) begin
         chk("det", det, m_moore ? prev : mt);
         chk("det_s", det_s, m_moore ? prev : mt);
      end
      chk("cnt", cnt, m_cnt > 65535 ? 65535 : m_cnt);
      chk("sat", sat, m_cnt > 65535);
      chk("cnt_s", cnt_s, m_cnt > 7 ? 7 : m_cnt);
      chk("sat_s", sat_s, m_cnt > 7);
      @(posedge clk);
      #1;
      if (r) begin
         q.delete(); m_pat = 4'b1011; m_ovl = 1'b1; m_moore = 1'b0; m_cnt = 0; prev = 1'b0;
      end else if (c) begin
         q.delete(); m_pat = p; m_ovl = o; m_moore = m; m_cnt = 0; prev = 1'b0;
      end else begin
         prev = mt;
         if (v) begin
            q.push_back(d);
            if (q.size() > PAT_W - 1) void'(q.pop_front());
         end
         if (mt) begin
            m_cnt++;
            if (!m_ovl) q.delete();
         end
      end
   endtask

   task automatic feed(input string s);
      for (int i = 0; i < s.len(); i++)
         step(1'b0, 1'b0, s[i] != "_", s[i] != "0", 4'h0, 1'b0, 1'b0);
   endtask

   task automatic load(input logic [3:0] p, input bit o, input bit m);
      step(1'b0, 1'b1, 1'b1, 1'b1, p, o, m);
   endtask

   initial begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0);
      feed("1011011");
      chk("ovl_mealy_cnt", cnt, 2);
      load(4'b1011, 1'b0, 1'b0);
      feed("1011011");
      chk("nonovl_cnt", cnt, 1);
      load(4'b1011, 1'b1, 1'b1);
      feed("1011011");
      feed("0");
      chk("moore_cnt", cnt, 2);
      load(4'b1011, 1'b1, 1'b0);
      feed("10___11");
      chk("gap_cnt", cnt, 1);
      load(4'b1011, 1'b1, 1'b0);
      feed("1");
      repeat (9) feed("011");
      chk("sat_cnt3", cnt_s, 7);
      chk("sat_flag3", sat_s, 1);
      chk("sat_cnt16", cnt, 9);
      load(4'b1011, 1'b1, 1'b0);
      chk("clr_cnt3", cnt_s, 0);
      chk("clr_flag3", sat_s, 0);
      feed("101");
      step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
      feed("1");
      chk("rst_mid_cnt", cnt, 0);
      feed("011");
      chk("rst_after_cnt", cnt, 1);
      load(4'b0110, 1'b1, 1'b0);
      feed("0110");
      chk("cfg_drop_cnt", cnt, 1);
      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 199) == 0, $urandom_range(0, 79) == 0, $urandom_range(0, 3) != 0,
              1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
